// File: rtl/cpu_trace_pkg.sv
// Shared types for the CPU trace buffer: record layout, word index and FSM codes.
package cpu_trace_pkg;

    localparam int RECORD_WORDS = 4;
    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef enum logic [$clog2(RECORD_WORDS)-1:0] {
        WI_PC   = 2'd0,
        WI_INST = 2'd1,
        WI_ALUC = 2'd2,
        WI_DATA = 2'd3
    } word_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] aluc;
        logic [31:0] data;
    } trace_rec_t;

    function automatic logic [31:0] rec_word(input trace_rec_t r, input word_idx_t wi);
        case (wi)
            WI_PC:   return r.pc;
            WI_INST: return r.inst;
            WI_ALUC: return r.aluc;
            default: return r.data;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; exposes the head and the entry behind it so the
// reader can move to the next record without a bubble.
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t wdata,
    output trace_rec_t head,
    output trace_rec_t head_next,
    output logic [AW:0] count
);

    trace_rec_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push   = push && (count != (AW+1)'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

    // NOTE: storage has no reset; only pointers and count decide what is valid,
    // which keeps the array as plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures {pc,inst,aluc,data} records and streams them out one 32-bit word per
// beat; records arriving while full are counted as drops.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic [31:0] aluc,
    input  logic [31:0] data,
    input  logic        rd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic [AW:0] count,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    input  logic        clr_ovf
);

    state_t     state;
    word_idx_t  wi;
    word_idx_t  next_wi;
    trace_rec_t rec_in;
    trace_rec_t head;
    trace_rec_t head_next;
    trace_rec_t nxt_rec;
    trace_rec_t src;
    logic       full;
    logic       push;
    logic       drop;
    logic       beat;
    logic       pop;
    logic       more;

    assign rec_in  = {pc, inst, aluc, data};
    assign full    = (count == (AW+1)'(DEPTH));
    assign push    = cap_en && !full;
    assign drop    = cap_en && full;
    assign beat    = rd_valid && rd_ready;
    assign pop     = (state == ST_SEND) && beat && (wi == WI_DATA);
    assign next_wi = word_idx_t'(wi + 2'd1);

    // A record pushed while the last stored one pops is forwarded straight from
    // the inputs, since it is not yet readable from the array.
    assign more    = (count > (AW+1)'(1)) || push;
    assign nxt_rec = (count > (AW+1)'(1)) ? head_next : rec_in;
    assign src     = (wi == WI_DATA) ? nxt_rec : head;

    trace_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (rec_in),
        .head      (head),
        .head_next (head_next),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wi       <= WI_PC;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state    <= ST_SEND;
                        wi       <= WI_PC;
                        rd_valid <= 1'b1;
                        rd_data  <= head.pc;
                        rd_last  <= 1'b0;
                    end
                end
                default: begin
                    if (beat) begin
                        if (wi == WI_DATA && !more) begin
                            state    <= ST_IDLE;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                        end else begin
                            wi      <= next_wi;
                            rd_data <= rec_word(src, next_wi);
                            rd_last <= (next_wi == WI_DATA);
                        end
                    end
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear wins: the clear is applied first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)                    drop_cnt <= 8'd1;
            else if (drop_cnt != DROP_MAX)  drop_cnt <= drop_cnt + 8'd1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: directed stimulus queues expected
// words; a negedge monitor compares every accepted beat.
module tb_cpu_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cap_en = 1'b0;
    logic [31:0] pc = '0, inst = '0, aluc = '0, data = '0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_ovf = 1'b0;

    typedef struct {
        logic [31:0] word;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   beat_log[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    cpu_trace_buffer #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en),
        .pc       (pc),
        .inst     (inst),
        .aluc     (aluc),
        .data     (data),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: a beat completes at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rst && rd_valid && rd_ready) begin
            exp_t e;
            checks++;
            beat_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data=%h last=%b, expected no beat", rd_data, rd_last);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e.word || rd_last !== e.last) begin
                    errors++;
                    $display("FAIL beat: got data=%h last=%b, expected data=%h last=%b",
                             rd_data, rd_last, e.word, e.last);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input logic [31:0] p, i, a, d);
        exp_q.push_back('{p, 1'b0});
        exp_q.push_back('{i, 1'b0});
        exp_q.push_back('{a, 1'b0});
        exp_q.push_back('{d, 1'b1});
    endtask

    task automatic capture(input logic [31:0] p, i, a, d);
        pc = p; inst = i; aluc = a; data = d;
        cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0 && !rd_valid) break;
            tick();
        end
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_valid_low"}, rd_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset with cap_en high
        rst = 1'b0; cap_en = 1'b1; pc = 32'h99;
        tick(); tick();
        check("rst_valid", rd_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_drop", drop_cnt, 0);
        check("rst_data", rd_data, 0);
        cap_en = 1'b0; rst = 1'b1;
        tick();
        check("rst_count_after", count, 0);

        // 2: single record, latency and last flag
        rd_ready = 1'b1;
        expect_rec(32'h4, 32'h20010005, 32'h5, 32'h0);
        capture(32'h4, 32'h20010005, 32'h5, 32'h0);
        check("lat_valid_t", rd_valid, 1'b0);
        check("lat_count", count, 1);
        tick();
        check("lat_valid_t1", rd_valid, 1'b1);
        check("lat_data_t1", rd_data, 32'h4);
        wait_drain("single");
        check("single_count", count, 0);

        // 3: backpressure then toggling ready
        rd_ready = 1'b0;
        expect_rec(32'h4, 32'h20010005, 32'h5, 32'h0);
        capture(32'h4, 32'h20010005, 32'h5, 32'h0);
        tick();
        for (int n = 0; n < 3; n++) begin
            check("bp_valid", rd_valid, 1'b1);
            check("bp_data", rd_data, 32'h4);
            tick();
        end
        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0) break;
            rd_ready = (n % 2 == 0);
            tick();
        end
        rd_ready = 1'b1;
        wait_drain("bp");

        // 4: overflow, saturation, clear-vs-drop priority, full+pop drop
        rd_ready = 1'b0;
        for (int n = 0; n < 18; n++) begin
            if (n < 16) expect_rec(n * 4, 32'h1000 + n, 32'h2000 + n, 32'h3000 + n);
            capture(n * 4, 32'h1000 + n, 32'h2000 + n, 32'h3000 + n);
        end
        check("ovf_count", count, 16);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_drop", drop_cnt, 2);
        cap_en = 1'b1;
        for (int n = 0; n < 260; n++) tick();
        check("sat_drop", drop_cnt, 255);
        clr_ovf = 1'b1;
        tick();
        check("clr_drop_wins_flag", overflow, 1'b1);
        check("clr_drop_wins_cnt", drop_cnt, 1);
        cap_en = 1'b0;
        tick();
        clr_ovf = 1'b0;
        check("clr_flag", overflow, 1'b0);
        check("clr_cnt", drop_cnt, 0);
        check("clr_count", count, 16);
        rd_ready = 1'b1;
        tick(); tick(); tick();
        pc = 32'hDEAD; cap_en = 1'b1;
        tick();
        cap_en = 1'b0;
        check("fullpop_drop", drop_cnt, 1);
        check("fullpop_count", count, 15);
        wait_drain("ovf");
        check("ovf_end_count", count, 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // 5: reset mid-record
        rd_ready = 1'b0;
        capture(32'h100, 32'h101, 32'h102, 32'h103);
        capture(32'h200, 32'h201, 32'h202, 32'h203);
        capture(32'h300, 32'h301, 32'h302, 32'h303);
        tick();
        exp_q.push_back('{32'h100, 1'b0});
        exp_q.push_back('{32'h101, 1'b0});
        rd_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("midrst_valid", rd_valid, 1'b0);
        check("midrst_count", count, 0);
        rst = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        check("midrst_no_words", exp_q.size(), 0);
        check("midrst_valid_after", rd_valid, 1'b0);

        // 6: back-to-back records
        rd_ready = 1'b0;
        expect_rec(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        expect_rec(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        capture(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        capture(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        tick();
        beat_log.delete();
        rd_ready = 1'b1;
        wait_drain("b2b");
        check("b2b_beats", beat_log.size(), 8);
        if (beat_log.size() == 8)
            check("b2b_span", beat_log[7] - beat_log[0], 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
